pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning PC/memory address width in bits (1024-word BRAM).
REQ-002 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port PCe  input  1  PC update enable from control FSM.
REQ-006 SHALL have port PCsrc  input  2  next-PC select: 00 PC+1, 01 PC+branch_disp, 10 rtarget, 11 illegal.
REQ-007 SHALL have port branch_disp  input  16  sign-extended branch displacement.
REQ-008 SHALL have port rtarget  input  16  jump target (register busB).
REQ-009 SHALL have port LSCntl  input  1  memory address select: 0 PC, 1 addr_reg.
REQ-010 SHALL have port addr_reg  input  16  load/store address (register busA).
REQ-011 SHALL have port pc  output  PC_W  current PC register.
REQ-012 SHALL have port mem_addr  output  PC_W  BRAM port address.
REQ-013 SHALL have port taken  output  1  one-cycle pulse: non-sequential PC update occurred last edge.
REQ-014 SHALL have port halted  output  1  sticky: branch-to-self detected.
REQ-015 SHALL have port fault  output  1  sticky: PCe with PCsrc=11 seen.
REQ-016 SHALL have port retired  output  32  count of PC updates (0 when stats disabled).
REQ-017 SHALL have port taken_cnt  output  16  count of taken branches/jumps (0 when stats disabled).

Function
REQ-018 SHALL, on a rising edge with PCe=1 and PCsrc=00, load pc <= pc+1 modulo 2^PC_W.
REQ-019 SHALL, with PCe=1 and PCsrc=01, load pc <= (pc + branch_disp[PC_W-1:0]) modulo 2^PC_W; pc is the branch's own address, so disp=0 targets itself.
REQ-020 SHALL, with PCe=1 and PCsrc=10, load pc <= rtarget[PC_W-1:0]; upper bits ignored.
REQ-021 SHALL, with PCe=1 and PCsrc=11, hold pc, set fault, not increment any counter.
REQ-022 SHALL hold pc whenever PCe=0, regardless of PCsrc.
REQ-023 SHALL drive mem_addr combinationally: LSCntl=1 -> addr_reg[PC_W-1:0], else pc; zero latency.
REQ-024 SHALL assert taken for exactly the one cycle after an edge with PCe=1 and PCsrc in {01,10}; deasserted otherwise.
REQ-025 SHALL set halted when PCe=1, PCsrc=01, branch_disp=0, or PCe=1, PCsrc=10, rtarget[PC_W-1:0]=pc; pc still loads per REQ-019/020 (unchanged).
REQ-026 SHALL keep halted and fault set until reset; no other clear.
REQ-027 SHALL wrap pc from 2^PC_W-1 to 0 on PC+1 and on negative/positive displacement overflow without flagging.
REQ-028 SHALL give REQ-021 priority: PCsrc=11 never sets halted or taken.

Reset
REQ-029 SHALL, while rst=1, force pc=RESET_PC, taken=0, halted=0, fault=0, retired=0, taken_cnt=0, independent of clk.
REQ-030 SHALL ignore PCe on any edge where rst=1; first update possible on the first edge after rst falls.
REQ-031 SHALL, on rst mid-branch (PCe=1 and rst=1), discard the update and leave pc=RESET_PC.

Configuration
REQ-032 SHALL compile statistics counters only when macro PC_STATS_EN is defined.
REQ-033 SHALL, with PC_STATS_EN, increment retired on every edge with PCe=1 and PCsrc!=11 (wrap at 2^32), and taken_cnt with taken's trigger (saturate at 16'hFFFF).
REQ-034 SHALL, without PC_STATS_EN, tie retired and taken_cnt to 0 and infer no counter flops.

Verification
REQ-035 SHALL cover: reset, then 3 edges PCe=1 PCsrc=00 -> pc=0,1,2,3; taken stays 0; retired=3 (stats on).
REQ-036 SHALL cover: pc=5, PCe=1 PCsrc=01 disp=16'hFFFD -> pc=2, taken=1 for one cycle, taken_cnt=1.
REQ-037 SHALL cover: pc=1023, PCsrc=00 -> pc=0; then PCsrc=10 rtarget=16'hF07A -> pc=0x07A (PC_W=10).
REQ-038 SHALL cover: pc=8, PCsrc=01 disp=0 -> halted=1, pc=8; PCsrc=11 -> fault=1, pc holds, retired unchanged.
REQ-039 SHALL cover: LSCntl=1 addr_reg=16'h0123 -> mem_addr=0x123 same cycle; LSCntl=0 -> mem_addr=pc.
REQ-040 SHALL cover: rst pulsed mid-run with PCe=1 -> pc=RESET_PC, all flags/counters 0 asynchronously.

Source files
------------

// File: rtl/pc_unit_if.sv
// Bundle of the PC unit's control inputs and status outputs.
// The control FSM drives it through the master modport; the PC unit uses the slave modport.
interface pc_unit_if #(
  parameter int unsigned PC_W = 10
);
  logic            PCe;
  logic [1:0]      PCsrc;
  logic [15:0]     branch_disp;
  logic [15:0]     rtarget;
  logic            LSCntl;
  logic [15:0]     addr_reg;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] mem_addr;
  logic            taken;
  logic            halted;
  logic            fault;
  logic [31:0]     retired;
  logic [15:0]     taken_cnt;

  modport master (
    output PCe, PCsrc, branch_disp, rtarget, LSCntl, addr_reg,
    input  pc, mem_addr, taken, halted, fault, retired, taken_cnt
  );

  modport slave (
    input  PCe, PCsrc, branch_disp, rtarget, LSCntl, addr_reg,
    output pc, mem_addr, taken, halted, fault, retired, taken_cnt
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with branch/jump select, BRAM address mux and sticky halt/fault flags.
// Define PC_STATS_EN to build the retired / taken_cnt statistics counters.
module pc_unit #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst,
  pc_unit_if.slave     bus
);

  localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;
  logic            retire;

  // Upper address bits beyond PC_W are intentionally ignored.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{bus.addr_reg, bus.rtarget};

  assign retire = bus.PCe && (bus.PCsrc != 2'b11);

  always_comb begin
    pc_d     = pc_q;
    taken_d  = 1'b0;
    halted_d = halted_q;
    fault_d  = fault_q;
    if (bus.PCe) begin
      unique case (bus.PCsrc)
        2'b00: pc_d = pc_q + PC_W'(1);
        2'b01: begin
          pc_d    = pc_q + bus.branch_disp[PC_W-1:0];
          taken_d = 1'b1;
          if (bus.branch_disp == 16'h0000) halted_d = 1'b1;
        end
        2'b10: begin
          pc_d    = bus.rtarget[PC_W-1:0];
          taken_d = 1'b1;
          if (bus.rtarget[PC_W-1:0] == pc_q) halted_d = 1'b1;
        end
        2'b11: fault_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= ResetPc;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

`ifdef PC_STATS_EN
  logic [31:0] retired_q;
  logic [15:0] taken_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q   <= 32'd0;
      taken_cnt_q <= 16'd0;
    end else begin
      if (retire) retired_q <= retired_q + 32'd1;
      // Saturates rather than wraps.
      if (taken_d && (taken_cnt_q != 16'hFFFF)) taken_cnt_q <= taken_cnt_q + 16'd1;
    end
  end

  assign bus.retired   = retired_q;
  assign bus.taken_cnt = taken_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign bus.retired   = 32'd0;
  assign bus.taken_cnt = 16'd0;
`endif

  assign bus.pc       = pc_q;
  assign bus.mem_addr = bus.LSCntl ? bus.addr_reg[PC_W-1:0] : pc_q;
  assign bus.taken    = taken_q;
  assign bus.halted   = halted_q;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_pc_unit.sv
// Randomized bench for pc_unit against an arithmetic reference model of the PC rules.
module tb_pc_unit;
  localparam int unsigned PcW     = 10;
  localparam int unsigned ResetPc = 0;
  localparam int unsigned Mod     = 1 << PcW;
`ifdef PC_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_unit_if #(.PC_W(PcW)) bus ();

  pc_unit #(.PC_W(PcW), .RESET_PC(ResetPc)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int unsigned m_pc, m_ret, m_tc;
  bit          m_taken, m_halted, m_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = ResetPc; m_ret = 0; m_tc = 0;
    m_taken = 0; m_halted = 0; m_fault = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"},     32'(bus.pc),        32'(m_pc));
    check({tag, ".taken"},  32'(bus.taken),     32'(m_taken));
    check({tag, ".halted"}, 32'(bus.halted),    32'(m_halted));
    check({tag, ".fault"},  32'(bus.fault),     32'(m_fault));
    check({tag, ".ret"},    bus.retired,        StatsEn ? m_ret : 32'd0);
    check({tag, ".tcnt"},   32'(bus.taken_cnt), StatsEn ? m_tc : 32'd0);
  endtask

  // Called at posedge+1: drive, check address mux, clock one edge, check state.
  task automatic step(input string tag, input bit pce, input bit [1:0] src,
                      input bit [15:0] disp, input bit [15:0] rt,
                      input bit ls, input bit [15:0] ar);
    bus.PCe = pce; bus.PCsrc = src; bus.branch_disp = disp; bus.rtarget = rt;
    bus.LSCntl = ls; bus.addr_reg = ar;
    #1;
    check({tag, ".maddr"}, 32'(bus.mem_addr), ls ? 32'(ar % Mod) : 32'(m_pc));
    @(posedge clk);
    m_taken = 0;
    if (pce) begin
      case (src)
        2'd0: begin m_pc = (m_pc + 1) % Mod; m_ret++; end
        2'd1: begin
          if (disp == 0) m_halted = 1;
          m_pc = (m_pc + disp) % Mod;
          m_taken = 1; m_ret++;
          if (m_tc < 65535) m_tc++;
        end
        2'd2: begin
          if (rt % Mod == m_pc) m_halted = 1;
          m_pc = rt % Mod;
          m_taken = 1; m_ret++;
          if (m_tc < 65535) m_tc++;
        end
        default: m_fault = 1;
      endcase
    end
    #1;
    check_state(tag);
  endtask

  task automatic async_reset(input string tag);
    // Mid-cycle, with a branch pending.
    bus.PCe = 1'b1; bus.PCsrc = 2'b01; bus.branch_disp = 16'h0004;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_state({tag, ".async"});
    @(posedge clk);
    #1;
    check_state({tag, ".held"});
    rst = 1'b0;
  endtask

  task automatic random_steps(input int n);
    bit [1:0]  src;
    bit [15:0] disp, rt;
    int        r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 15));
      src  = (r < 8) ? 2'd0 : (r < 12) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      disp = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
      rt   = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rt = {rt[15:PcW], 10'(m_pc)};
      step("rnd", $urandom_range(0, 3) != 0, src, disp, rt,
           1'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.PCe = 0; bus.PCsrc = 0; bus.branch_disp = 0; bus.rtarget = 0;
    bus.LSCntl = 0; bus.addr_reg = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b0;

    step("inc1", 1, 2'd0, 16'h0, 16'h0, 0, 16'h0);
    step("inc2", 1, 2'd0, 16'h0, 16'h0, 0, 16'h0);
    step("inc3", 1, 2'd0, 16'h0, 16'h0, 0, 16'h0);
    step("idle", 0, 2'd1, 16'h7, 16'h9, 0, 16'h0);
    step("jmp5", 1, 2'd2, 16'h0, 16'h0005, 0, 16'h0);
    step("bneg", 1, 2'd1, 16'hFFFD, 16'h0, 0, 16'h0);
    step("after", 0, 2'd0, 16'h0, 16'h0, 0, 16'h0);
    step("jmpmax", 1, 2'd2, 16'h0, 16'h03FF, 0, 16'h0);
    step("wrap", 1, 2'd0, 16'h0, 16'h0, 0, 16'h0);
    step("jmphi", 1, 2'd2, 16'h0, 16'hF07A, 0, 16'h0);
    step("lsaddr", 0, 2'd0, 16'h0, 16'h0, 1, 16'h0123);
    step("lspc", 0, 2'd0, 16'h0, 16'h0, 0, 16'h0123);
    step("jmp8", 1, 2'd2, 16'h0, 16'h0008, 0, 16'h0);
    step("bself", 1, 2'd1, 16'h0000, 16'h0, 0, 16'h0);
    step("illeg", 1, 2'd3, 16'h0005, 16'h0022, 0, 16'h0);
    step("hold", 0, 2'd0, 16'h0, 16'h0, 0, 16'h0);

    async_reset("rst1");
    random_steps(300);
    async_reset("rst2");
    random_steps(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
